// File: rtl/pn_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// pn_seq_pkg : shared constants and types for the PN7 sequence checker
// Revision   : 1.0
//------------------------------------------------------------------------------
package pn_seq_pkg;

   localparam int PN_ORDER = 7;

   // Bit (i-1) selects history position i; positions 7, 4, 3 and 2 feed the recurrence.
   localparam logic [PN_ORDER-1:0] PN_TAPS = 7'b1001110;

   // Generator seed; its first seven output bits are 1,0,0,0,0,0,1.
   localparam logic [PN_ORDER-1:0] PN_SEED = 7'b1000001;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_HUNT = 2'd1,
      ST_LOCK = 2'd2
   } state_e;

   function automatic logic pn_feedback(input logic [PN_ORDER-1:0] vec);
      return ^(vec & PN_TAPS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pn7_predict.sv
`default_nettype none
//------------------------------------------------------------------------------
// pn7_predict : next-bit prediction from a 7-bit PN history (bit 0 = newest)
// Revision    : 1.0
//------------------------------------------------------------------------------
module pn7_predict
   import pn_seq_pkg::*;
(
   input  logic [PN_ORDER-1:0] vec_i,
   output logic                bit_o
);

   assign bit_o = pn_feedback(vec_i);

endmodule
`default_nettype wire

// File: rtl/pn_seq_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// pn_seq_checker : self-synchronising PN7 receive checker with BER counters
// Revision       : 1.0
//------------------------------------------------------------------------------
module pn_seq_checker
   import pn_seq_pkg::*;
#(
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_ERR = 8,
   parameter int WINDOW     = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             din_valid,
   input  logic             din,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int                WIN_W       = $clog2(WINDOW);
   localparam int                WERR_W      = $clog2(WINDOW + 1);
   localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] ERR_LIMIT   = WERR_W'(UNLOCK_ERR);
   localparam logic [WERR_W-1:0] WERR_ONE    = WERR_W'(1);
   localparam logic [WIN_W-1:0]  WIN_ONE     = WIN_W'(1);
   localparam logic [7:0]        LOCK_TARGET = 8'(LOCK_CNT);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   state_e              state_q,     state_d;
   logic [2:0]          fill_q,      fill_d;
   logic [7:0]          match_q,     match_d;
   logic [WIN_W-1:0]    win_cnt_q,   win_cnt_d;
   logic [WERR_W-1:0]   win_err_q,   win_err_d;
   logic [PN_ORDER-1:0] hist_q,      hist_d;
   logic [PN_ORDER-1:0] lfsr_q,      lfsr_d;
   logic                locked_q,    locked_d;
   logic                err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
   logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;

   logic                hist_pred;
   logic                lfsr_pred;
   logic [PN_ORDER-1:0] hist_shift;
   logic [7:0]          match_inc;
   logic [WERR_W-1:0]   win_err_inc;
   logic                mismatch;

   pn7_predict u_pred_hist (
      .vec_i (hist_q),
      .bit_o (hist_pred)
   );

   pn7_predict u_pred_lfsr (
      .vec_i (lfsr_q),
      .bit_o (lfsr_pred)
   );

   assign hist_shift  = {hist_q[PN_ORDER-2:0], din};
   assign match_inc   = match_q + 8'd1;
   assign win_err_inc = win_err_q + WERR_ONE;
   assign mismatch    = din ^ lfsr_pred;

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      hist_d      = hist_q;
      lfsr_d      = lfsr_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;
      bit_cnt_d   = bit_cnt_q;
      err_cnt_d   = err_cnt_q;

      if (din_valid) begin
         case (state_q)
            ST_FILL: begin
               hist_d = hist_shift;
               fill_d = fill_q + 3'd1;
               if (fill_q == 3'(PN_ORDER - 1)) begin
                  state_d = ST_HUNT;
               end
            end

            ST_HUNT: begin
               hist_d = hist_shift;
               // An all-zero history predicts zero forever, so it never counts as a match.
               if ((din == hist_pred) && (hist_q != '0)) begin
                  match_d = match_inc;
                  if (match_inc == LOCK_TARGET) begin
                     state_d  = ST_LOCK;
                     locked_d = 1'b1;
                     lfsr_d   = hist_shift;
                  end
               end else begin
                  match_d = '0;
               end
            end

            ST_LOCK: begin
               lfsr_d = {lfsr_q[PN_ORDER-2:0], lfsr_pred};
               if (!(&bit_cnt_q)) begin
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
               end
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (!(&err_cnt_q)) begin
                     err_cnt_d = err_cnt_q + CNT_ONE;
                  end
               end

               if (mismatch && (win_err_inc == ERR_LIMIT)) begin
                  state_d   = ST_FILL;
                  locked_d  = 1'b0;
                  fill_d    = '0;
                  match_d   = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else if (win_cnt_q == WIN_LAST) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + WIN_ONE;
                  if (mismatch) begin
                     win_err_d = win_err_inc;
                  end
               end
            end

            default: begin
               state_d = ST_FILL;
            end
         endcase
      end

      if (clr_cnt) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_FILL;
         fill_q      <= '0;
         match_q     <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         hist_q      <= '0;
         lfsr_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         bit_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         hist_q      <= hist_d;
         lfsr_q      <= lfsr_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         bit_cnt_q   <= bit_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign bit_cnt   = bit_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
